req_pend4: RTL

REQ_PEND4 -- requirements
Module: req_pend4

---
 rtl/req_pend4_if.sv | 21 ++
 rtl/req_pend4.sv | 78 +++++++
 2 files changed

// File: rtl/req_pend4_if.sv
// Request/acknowledge/mask bus between the pending-request block and its environment.
interface req_pend4_if;
    logic       R0, R1, R2, R3;
    logic       MLD;
    logic [3:0] MD;
    logic       ACK;
    logic       AY1, AY0;
    logic       CLR;
    logic       I0, I1, I2, I3;
    logic       OVF;

    modport master (
        output R0, R1, R2, R3, MLD, MD, ACK, AY1, AY0, CLR,
        input  I0, I1, I2, I3, OVF
    );

    modport slave (
        input  R0, R1, R2, R3, MLD, MD, ACK, AY1, AY0, CLR,
        output I0, I1, I2, I3, OVF
    );
endinterface

// File: rtl/req_pend4.sv
// Four-channel rising-edge request latch with mask, acknowledge and sticky overflow.
// Optional macro REQ_SYNC_EN inserts a 2-flop synchroniser on each request line.
module req_pend4 (
    input  logic       clk,
    input  logic       rst_n,
    req_pend4_if.slave bus
);
    logic [3:0] r_raw;
    logic [3:0] r_smp;
    logic [3:0] s_q, s_d;
    logic [3:0] p_q, p_d;
    logic [3:0] m_q, m_d;
    logic       ovf_q, ovf_d;
    logic [3:0] rise;
    logic [3:0] ack_vec;
    logic [3:0] pend_vis;

    assign r_raw = {bus.R3, bus.R2, bus.R1, bus.R0};

`ifdef REQ_SYNC_EN
    logic [3:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= r_raw;
            sync2_q <= sync1_q;
        end
    end

    assign r_smp = sync2_q;
`else
    assign r_smp = r_raw;
`endif

    always_comb begin
        ack_vec = '0;
        if (bus.ACK) begin
            ack_vec[{bus.AY1, bus.AY0}] = 1'b1;
        end

        rise = r_smp & ~s_q;
        s_d  = r_smp;
        m_d  = bus.MLD ? bus.MD : m_q;

        // A fresh edge wins over a same-cycle acknowledge; CLR beats both.
        if (bus.CLR) begin
            p_d   = '0;
            ovf_d = 1'b0;
        end else begin
            p_d   = (p_q & ~ack_vec) | rise;
            ovf_d = ovf_q | (|(rise & p_q & ~ack_vec));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            p_q   <= '0;
            m_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            p_q   <= p_d;
            m_q   <= m_d;
            ovf_q <= ovf_d;
        end
    end

    assign pend_vis = p_q & ~m_q;
    assign bus.I0   = pend_vis[0];
    assign bus.I1   = pend_vis[1];
    assign bus.I2   = pend_vis[2];
    assign bus.I3   = pend_vis[3];
    assign bus.OVF  = ovf_q;
endmodule
